// File: rtl/adler32_stream.sv
`timescale 1ns/1ps
// adler32_stream: multi-byte-per-beat Adler-32 engine with keep mask,
// registered ready, optional seeding and per-message byte count.
module adler32_stream #(
  parameter int unsigned BYTES = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               data_valid,
  input  logic [8*BYTES-1:0] data,
  input  logic [BYTES-1:0]   data_keep,
  input  logic               last_data,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  output logic               data_ready,
  output logic               checksum_valid,
  output logic [31:0]        checksum,
  output logic [31:0]        byte_count
);

  localparam logic [18:0] MOD    = 19'd65521;
  localparam logic [15:0] MOD16  = 16'd65521;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic [31:0] ck_q, ck_d;
  logic [31:0] bc_q, bc_d;

  logic        accept;
  logic [15:0] a_start, b_start;
  logic [15:0] a_beat, b_beat;
  logic [31:0] cnt_beat;

  // (x + y) mod 65521 for x < 65521 and y < 65521; 19-bit intermediate sum
  function automatic logic [15:0] add_mod(input logic [15:0] x, input logic [15:0] y);
    logic [18:0] s;
    s = {3'b000, x} + {3'b000, y};
    return (s >= MOD) ? 16'(s - MOD) : 16'(s);
  endfunction

  // A seed half may be up to 0xFFFF; one subtraction brings it into range
  function automatic logic [15:0] fold_seed(input logic [15:0] v);
    return (v >= MOD16) ? v - MOD16 : v;
  endfunction

  assign accept = data_valid && ready_q;

  // Start values for the current beat: the seed overrides A/B only in IDLE
  always_comb begin
    a_start = a_q;
    b_start = b_q;
    if (state_q == IDLE && seed_load) begin
      a_start = fold_seed(seed[15:0]);
      b_start = fold_seed(seed[31:16]);
    end
  end

  // Fold all kept lanes of the beat in lane order, bit-exact to serial bytes
  always_comb begin
    a_beat   = a_start;
    b_beat   = b_start;
    cnt_beat = cnt_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (data_keep[i]) begin
        a_beat   = add_mod(a_beat, {8'h00, data[8*i +: 8]});
        b_beat   = add_mod(b_beat, a_beat);
        cnt_beat = cnt_beat + 32'd1;
      end
    end
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ck_d    = ck_q;
    bc_d    = bc_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        // A seed loaded in IDLE without a beat is kept for the next beat
        if (state_q == IDLE && seed_load) begin
          a_d = a_start;
          b_d = b_start;
        end
        if (accept) begin
          if (last_data) begin
            ck_d    = {b_beat, a_beat};
            bc_d    = cnt_beat;
            valid_d = 1'b1;
            a_d     = 16'd1;
            b_d     = '0;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            a_d     = a_beat;
            b_d     = b_beat;
            cnt_d   = cnt_beat;
            state_d = ACCUM;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != DONE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= 16'd1;
      b_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      ck_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      ck_q    <= ck_d;
      bc_q    <= bc_d;
    end
  end

  assign data_ready     = ready_q;
  assign checksum_valid = valid_q;
  assign checksum       = ck_q;
  assign byte_count     = bc_q;

endmodule
